// File: rtl/div_iter_pkg.sv
// Shared encodings for the iterative restoring divider.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage : div_iter_pkg

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, select.
module div_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem[WIDTH] set means the true shifted value exceeds WIDTH+1 bits, so it is >= divisor.
  always_comb begin
    shifted    = {rem[WIDTH-1:0], next_bit};
    diff       = shifted - {1'b0, divisor};
    q_bit_c    = rem[WIDTH] | (shifted >= {1'b0, divisor});
    rem_next_c = q_bit_c ? diff : shifted;
  end

endmodule : div_iter_step

// File: rtl/div_iter.sv
// Multi-cycle signed/unsigned divider: one quotient bit per cycle, divide-by-zero flagged.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               dbz_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;

  logic [WIDTH:0]     rem_nxt_c;
  logic               q_bit_c;
  logic [WIDTH-1:0]   quo_nxt_c;
  logic [WIDTH-1:0]   mag_a_c, mag_b_c;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem        (rem_q),
    .next_bit   (quo_q[WIDTH-1]),
    .divisor    (dvs_q),
    .rem_next_c (rem_nxt_c),
    .q_bit_c    (q_bit_c)
  );

  // Operand magnitudes; most-negative wraps to itself, which is its correct unsigned magnitude.
  always_comb begin
    mag_a_c   = (signed_div_i && opdata1_i[WIDTH-1]) ? WIDTH'(-opdata1_i) : opdata1_i;
    mag_b_c   = (signed_div_i && opdata2_i[WIDTH-1]) ? WIDTH'(-opdata2_i) : opdata2_i;
    quo_nxt_c = {quo_q[WIDTH-2:0], q_bit_c};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and datapath updates; aborts take priority over completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    dbz_d     = dbz_q;

    case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        dbz_d    = 1'b0;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d   = DIV_ON;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = mag_a_c;
            dvs_d     = mag_b_c;
            neg_quo_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_d = signed_div_i & opdata1_i[WIDTH-1];
          end
        end
      end
      DIV_BY_ZERO: begin
        if (annul_i || start_i == DIV_STOP) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
          dbz_d    = 1'b1;
        end
      end
      DIV_ON: begin
        if (annul_i || start_i == DIV_STOP) begin
          state_d = DIV_FREE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          rem_d = rem_nxt_c;
          quo_d = quo_nxt_c;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DIV_END;
            ready_d  = DIV_RESULT_READY;
            dbz_d    = 1'b0;
            result_d = {neg_rem_q ? WIDTH'(-rem_nxt_c[WIDTH-1:0]) : rem_nxt_c[WIDTH-1:0],
                        neg_quo_q ? WIDTH'(-quo_nxt_c) : quo_nxt_c};
          end
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
          dbz_d    = 1'b0;
        end
      end
      default: state_d = DIV_FREE;
    endcase

    busy_d = (state_d == DIV_ON) || (state_d == DIV_BY_ZERO);
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign dbz_o    = dbz_q;
  assign busy_o   = busy_q;

endmodule : div_iter

// File: tb/tb_div_iter.sv
// Randomized and directed checks of div_iter against an arithmetic reference model.
module tb_div_iter;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           signed_div = 1'b0;
  logic [W-1:0]   op1 = '0;
  logic [W-1:0]   op2 = '0;
  logic           start = 1'b0;
  logic           annul = 1'b0;
  logic [2*W-1:0] result;
  logic           ready;
  logic           busy;
  logic           dbz;

  int n_assert = 0;
  int n_fail   = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .busy_o       (busy),
    .dbz_o        (dbz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {remainder, quotient} from plain 64-bit arithmetic (truncating division).
  function automatic logic [2*W-1:0] ref_div(input logic sgn, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Issue one request, scramble operands while it runs, check latency/result, hold, release.
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold);
    logic [2*W-1:0] exp;
    int lat;
    int exp_lat;
    exp     = ref_div(sgn, a, b);
    exp_lat = (b == '0) ? 2 : W + 1;
    signed_div = sgn;
    op1 = a;
    op2 = b;
    start = 1'b1;
    annul = 1'b0;
    lat = 0;
    while (ready !== 1'b1 && lat < 3 * W) begin
      tick();
      lat++;
      if (lat == 1) check("busy_first_cycle", 64'(busy), 64'd1);
      op1 = $urandom;
      op2 = $urandom;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", result, exp);
    check("dbz", 64'(dbz), 64'(b == '0));
    for (int i = 0; i < hold; i++) begin
      annul = 1'b1;
      tick();
      check("hold_ready", 64'(ready), 64'd1);
      check("hold_result", result, exp);
    end
    annul = 1'b0;
    start = 1'b0;
    tick();
    check("release_ready", 64'(ready), 64'd0);
    check("release_result", result, '0);
    check("release_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic seen;
    logic [W-1:0] ra, rb;

    // Reset state
    tick();
    tick();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    check("rst_result", result, '0);
    rst = 1'b0;
    tick();

    // Directed cases
    run_div(1'b0, 32'd100, 32'd7, 0);
    check("u100_7_const", result, '0);
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b0, 32'h1234_5678, 32'd0, 0);
    run_div(1'b1, 32'h8000_0000, 32'd0, 1);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_div(1'b0, 32'd5, 32'hFFFF_FFFF, 0);

    // Start with annul while idle is ignored
    op1 = 32'd9; op2 = 32'd3; start = 1'b1; annul = 1'b1;
    tick(); tick(); tick();
    check("idle_annul_busy", 64'(busy), 64'd0);
    check("idle_annul_ready", 64'(ready), 64'd0);
    start = 1'b0; annul = 1'b0;
    tick();

    // Annul in cycle 10, then an immediate new request
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("annul_busy_before", 64'(busy), 64'd1);
    annul = 1'b1;
    tick();
    check("annul_busy_after", 64'(busy), 64'd0);
    check("annul_ready_after", 64'(ready), 64'd0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10, 0);

    // Reset in cycle 20 of a divide
    op1 = 32'd77777; op2 = 32'd13; start = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_dbz", 64'(dbz), 64'd0);
    check("midrst_result", result, '0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    run_div(1'b1, 32'hFFFF_0000, 32'd12345, 0);

    // start dropped in cycle 15: no ready ever
    op1 = 32'd4444; op2 = 32'd5; start = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    start = 1'b0;
    tick();
    check("drop_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready === 1'b1) seen = 1'b1;
    end
    check("drop_no_ready", 64'(seen), 64'd0);

    // Result stable over 5 held cycles in DONE
    run_div(1'b1, 32'd123456, 32'hFFFF_FFF9, 5);

    // Randomized operations
    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (n % 7 == 3) ra = 32'h8000_0000;
      run_div(1'($urandom_range(0, 1)), ra, rb, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_div_iter

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 signed_div_i  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-005 opdata1_i  input  WIDTH  dividend; sampled with start.
REQ-006 opdata2_i  input  WIDTH  divisor; sampled with start.
REQ-007 start_i  input  1  request; held high by the requester until ready_o is seen.
REQ-008 annul_i  input  1  abort the in-flight divide.
REQ-009 result_o  output  2*WIDTH  {remainder[2*WIDTH-1:WIDTH], quotient[WIDTH-1:0]}.
REQ-010 ready_o  output  1  result_o valid.
REQ-011 busy_o  output  1  high in ON or DBZ state.
REQ-012 dbz_o  output  1  high with ready_o when the divisor was zero.

Function
REQ-013 FSM states IDLE, DBZ, ON, DONE; one bit of quotient per ON cycle (restoring algorithm).
REQ-014 IDLE: start_i=1, annul_i=0, divisor≠0 -> ON with counter=0 and operands latched; divisor=0 -> DBZ; else stay IDLE.
REQ-015 IDLE with start_i=1 and annul_i=1 -> stay IDLE; request ignored.
REQ-016 ON: counter increments each cycle; after WIDTH ON cycles -> DONE.
REQ-017 Latency: start_i first sampled in cycle 0 -> ON cycles 1..WIDTH -> ready_o high from cycle WIDTH+1.
REQ-018 DBZ: one cycle, then DONE with result_o=0 and dbz_o=1; ready_o high from cycle 2.
REQ-019 ON or DBZ with annul_i=1 or start_i=0 -> IDLE next cycle; ready_o never asserts for that request.
REQ-020 DONE: ready_o, dbz_o and result_o held stable while start_i=1; start_i=0 -> IDLE next cycle, ready_o, dbz_o and result_o go to 0.
REQ-021 Only start_i=0 leaves DONE; annul_i in DONE is ignored.
REQ-022 New operand values while in ON or DONE are ignored; latched operands alone determine the result.
REQ-023 Signed mode: divide magnitudes. Quotient is negated when operand signs differ. Remainder takes the sign of the dividend.
REQ-024 Signed most-negative / -1: quotient = most-negative value (WIDTH-bit wrap), remainder = 0, dbz_o = 0.
REQ-025 Unsigned mode: no sign handling; full WIDTH-bit range.
REQ-026 The partial remainder datapath is WIDTH+1 bits wide; no internal overflow for any operands.

Reset
REQ-027 rst=1 at any edge -> IDLE, counter=0, result_o=0, ready_o=0, dbz_o=0, busy_o=0, regardless of state.
REQ-028 An operation interrupted by reset produces no ready_o; the first request after reset completes with the normal latency.

Structure
REQ-029 State encodings (DivFree, DivByZero, DivOn, DivEnd) and ready/start level constants belong in the shared defines header.
REQ-030 One sub-module is natural: div_iter_step, a combinational single restoring-subtract step (WIDTH+1-bit subtract and select).
REQ-031 Sign pre- and post-processing and the FSM stay in div_iter.

Verification (WIDTH=32)
REQ-032 Unsigned 100/7 -> ready_o rises in cycle 33; result_o = {32'd2, 32'd14}; dbz_o=0.
REQ-033 Signed 0xFFFFFF9C/7 (-100/7) -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-034 Divisor 0, any dividend -> ready_o in cycle 2, result_o=0, dbz_o=1; start_i low -> ready_o low next cycle.
REQ-035 Annul: annul_i=1 in cycle 10 of a divide -> busy_o low in cycle 11, no ready_o; an immediate 0xFFFFFFFF/0x10 unsigned request -> quotient 0x0FFFFFFF, remainder 0xF.
REQ-036 Reset and release: rst=1 in cycle 20 of a divide -> all outputs 0 next cycle. start_i=0 in cycle 15 of a divide -> IDLE, no ready_o. start_i held 5 cycles in DONE -> result stable for all 5.
